// File: rtl/aes_pkg.sv
// Shared AES definitions for the round datapath stages.
// The inverse S-box function exists only when SUB_BYTES_INV_EN is defined.
package aes_pkg;

  parameter int unsigned AES_BLOCK_W   = 128;
  parameter int unsigned AES_NUM_BYTES = 16;

  typedef logic [AES_BLOCK_W-1:0] aes_state_t;
  typedef logic [7:0]             aes_byte_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} aes_fsm_e;

  function automatic aes_byte_t aes_xtime(input aes_byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t aes_gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t acc;
    aes_byte_t p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = aes_xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic aes_byte_t aes_gf_inv(input aes_byte_t a);
    aes_byte_t r;
    aes_byte_t sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = aes_gf_mul(sq, sq);
      r  = aes_gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic aes_byte_t aes_rotl(input aes_byte_t a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic aes_byte_t aes_sbox_fwd(input aes_byte_t a);
    aes_byte_t b;
    b = aes_gf_inv(a);
    return b ^ aes_rotl(b, 1) ^ aes_rotl(b, 2) ^ aes_rotl(b, 3) ^ aes_rotl(b, 4) ^ 8'h63;
  endfunction

`ifdef SUB_BYTES_INV_EN
  function automatic aes_byte_t aes_sbox_inv(input aes_byte_t s);
    aes_byte_t b;
    b = aes_rotl(s, 1) ^ aes_rotl(s, 3) ^ aes_rotl(s, 6) ^ 8'h05;
    return aes_gf_inv(b);
  endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lane; forward only unless SUB_BYTES_INV_EN adds the inv select.
module aes_sbox
  import aes_pkg::*;
(
`ifdef SUB_BYTES_INV_EN
  input  logic      inv,
`endif
  input  aes_byte_t din,
  output aes_byte_t dout
);

`ifdef SUB_BYTES_INV_EN
  assign dout = inv ? aes_sbox_inv(din) : aes_sbox_fwd(din);
`else
  assign dout = aes_sbox_fwd(din);
`endif

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: BYTES_PER_CYCLE S-box lanes walk the 128-bit state chunk by chunk.
// SUB_BYTES_INV_EN adds the inv_mode port selecting the inverse S-box per block.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
`ifdef SUB_BYTES_INV_EN
  ,
  input  logic         inv_mode
`endif
);

  localparam int unsigned NCHUNK = AES_NUM_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : gen_bpc_check
    $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  aes_fsm_e   state_q, state_d;
  aes_state_t work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic accept;

  logic [3:0] lane_idx [BYTES_PER_CYCLE];
  aes_byte_t  sbox_in  [BYTES_PER_CYCLE];
  aes_byte_t  sbox_out [BYTES_PER_CYCLE];

`ifdef SUB_BYTES_INV_EN
  logic inv_q, inv_d;
  assign inv_d = accept ? inv_mode : inv_q;
`endif

  // Byte k lives at bits [127-8k -: 8]; ~idx gives 15-idx for the 4-bit index.
  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : gen_lane
    assign lane_idx[j] = 4'(cnt_q * BYTES_PER_CYCLE) + 4'(j);
    assign sbox_in[j]  = work_q[{~lane_idx[j], 3'b000} +: 8];

    aes_sbox u_sbox (
`ifdef SUB_BYTES_INV_EN
      .inv  (inv_q),
`endif
      .din  (sbox_in[j]),
      .dout (sbox_out[j])
    );
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      BUSY: begin
        busy = 1'b1;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
          work_d[{~lane_idx[j], 3'b000} +: 8] = sbox_out[j];
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        accept    = in_valid && out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new block may land in the same cycle the previous result is taken.
    if (accept) begin
      state_d = BUSY;
      work_d  = state_in;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SUB_BYTES_INV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`endif

  assign state_out = work_q;

endmodule
